// File: rtl/board_state.sv
// board_state: live card board with paired fill, LFSR shuffle,
// registered read port with RGB332 palette and pair-removal service.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   restart, seed          rebuild/reshuffle pulse and its seed (0 = default)
//   ready                  layout complete
//   rd_addr                read address
//   rd_color, rd_present   registered cell contents (0 if absent/invalid)
//   r, g, b                registered RGB332 palette colour of the cell
//   rm_req, rm_addr_a/b    pair-removal request
//   rm_ack, rm_match       removal response, one cycle after acceptance
//   remaining, board_clear cards left on the board, and board empty flag
module board_state #(
    parameter int          ROWS       = 6,
    parameter int          COLS       = 6,
    parameter int          ADDR_W     = 6,
    parameter int          NUM_COLORS = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [15:0]       seed,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_color,
    output logic              rd_present,
    output logic [2:0]        r,
    output logic [2:0]        g,
    output logic [1:0]        b,
    input  logic              rm_req,
    input  logic [ADDR_W-1:0] rm_addr_a,
    input  logic [ADDR_W-1:0] rm_addr_b,
    output logic              rm_ack,
    output logic              rm_match,
    output logic [ADDR_W:0]   remaining,
    output logic              board_clear
);

    localparam int N = ROWS * COLS;
    localparam logic [ADDR_W:0]   N_W    = (ADDR_W + 1)'(N);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N - 1);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_SHUF  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    localparam logic [7:0] PAL [16] = '{
        8'h93, 8'hA8, 8'hC5, 8'hE0, 8'h61, 8'hD4, 8'h56, 8'hFC,
        8'h1C, 8'h03, 8'h8E, 8'h49, 8'hF3, 8'h2B, 8'hB6, 8'hFF
    };

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       lfsr;
    logic [3:0]        color [N];
    logic [N-1:0]      present;

    // Accepted request waits one cycle here before being evaluated,
    // so every request sees the state left by the one before it.
    logic              pend_v;
    logic [ADDR_W-1:0] pend_a;
    logic [ADDR_W-1:0] pend_b;

    logic [ADDR_W-1:0] j;
    logic              fb;
    logic              swap_ok;
    logic              accept;
    logic              match;
    logic              rd_ok;
    logic [3:0]        rd_c;
    logic [7:0]        pal;
    logic [3:0]        fill_col;

    assign j        = lfsr[ADDR_W-1:0];
    assign fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign swap_ok  = (state == S_SHUF) && (j <= idx);
    assign accept   = rm_req && ready && !restart;
    assign fill_col = 4'((32'(idx) >> 1) % NUM_COLORS);

    assign match = pend_v && (pend_a != pend_b)
                && ({1'b0, pend_a} < N_W) && ({1'b0, pend_b} < N_W)
                && present[pend_a] && present[pend_b]
                && (color[pend_a] == color[pend_b]);

    assign rd_ok = ready && ({1'b0, rd_addr} < N_W) && present[rd_addr];
    assign rd_c  = color[rd_addr];
    assign pal   = PAL[rd_c];

    assign board_clear = ready && (remaining == '0);

    // Cell storage: fully rewritten by FILL, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!restart) begin
            if (state == S_FILL) begin
                color[idx]   <= fill_col;
                present[idx] <= 1'b1;
            end
            if (swap_ok) begin
                color[idx] <= color[j];
                color[j]   <= color[idx];
            end
            if (match) begin
                present[pend_a] <= 1'b0;
                present[pend_b] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FILL;
            idx        <= '0;
            lfsr       <= LFSR_SEED;
            ready      <= 1'b0;
            remaining  <= '0;
            rm_ack     <= 1'b0;
            rm_match   <= 1'b0;
            pend_v     <= 1'b0;
            pend_a     <= '0;
            pend_b     <= '0;
            rd_color   <= '0;
            rd_present <= 1'b0;
            r          <= '0;
            g          <= '0;
            b          <= '0;
        end else if (restart) begin
            state      <= S_FILL;
            idx        <= '0;
            lfsr       <= (seed != 16'd0) ? seed : LFSR_SEED;
            ready      <= 1'b0;
            remaining  <= '0;
            rm_ack     <= 1'b0;
            rm_match   <= 1'b0;
            pend_v     <= 1'b0;
            rd_color   <= '0;
            rd_present <= 1'b0;
            r          <= '0;
            g          <= '0;
            b          <= '0;
        end else begin
            rd_color   <= rd_ok ? rd_c : 4'd0;
            rd_present <= rd_ok;
            r          <= rd_ok ? pal[7:5] : 3'd0;
            g          <= rd_ok ? pal[4:2] : 3'd0;
            b          <= rd_ok ? pal[1:0] : 2'd0;

            rm_ack   <= pend_v;
            rm_match <= match;
            pend_v   <= accept;
            pend_a   <= rm_addr_a;
            pend_b   <= rm_addr_b;
            if (match) begin
                remaining <= remaining - (ADDR_W + 1)'(2);
            end

            unique case (state)
                S_FILL: begin
                    if (idx == LAST) begin
                        state <= S_SHUF;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_SHUF: begin
                    lfsr <= {lfsr[14:0], fb};
                    if (j <= idx) begin
                        if (idx == ADDR_W'(1)) begin
                            state     <= S_READY;
                            ready     <= 1'b1;
                            remaining <= N_W;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                S_READY: begin
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_state.sv
// tb_board_state: directed bench for board_state with a layout model
// and a scoreboard of expected read and removal results.
module tb_board_state;

    localparam int N  = 36;
    localparam int AW = 6;
    localparam int NC = 8;
    localparam logic [15:0] DSEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          restart = 1'b0;
    logic [15:0]   seed = 16'd0;
    logic          ready;
    logic [AW-1:0] rd_addr = '0;
    logic [3:0]    rd_color;
    logic          rd_present;
    logic [2:0]    r;
    logic [2:0]    g;
    logic [1:0]    b;
    logic          rm_req = 1'b0;
    logic [AW-1:0] rm_addr_a = '0;
    logic [AW-1:0] rm_addr_b = '0;
    logic          rm_ack;
    logic          rm_match;
    logic [AW:0]   remaining;
    logic          board_clear;

    board_state dut (
        .clk(clk), .rst_n(rst_n), .restart(restart), .seed(seed),
        .ready(ready), .rd_addr(rd_addr), .rd_color(rd_color),
        .rd_present(rd_present), .r(r), .g(g), .b(b),
        .rm_req(rm_req), .rm_addr_a(rm_addr_a), .rm_addr_b(rm_addr_b),
        .rm_ack(rm_ack), .rm_match(rm_match), .remaining(remaining),
        .board_clear(board_clear)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_rem = 0;
    int mshuf = 0;
    logic [7:0]  pal [16] = '{
        8'h93, 8'hA8, 8'hC5, 8'hE0, 8'h61, 8'hD4, 8'h56, 8'hFC,
        8'h1C, 8'h03, 8'h8E, 8'h49, 8'hF3, 8'h2B, 8'hB6, 8'hFF
    };
    logic [3:0]  mcol [N];
    logic [12:0] rd_q [$];
    logic        rm_q [$];
    int          pa [18];
    int          pb [18];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference layout: paired fill then LFSR-driven Fisher-Yates.
    task automatic build(input logic [15:0] sd);
        logic [15:0] l;
        logic [5:0]  j;
        logic [3:0]  t;
        logic        fb;
        int          i;
        l = sd;
        for (int k = 0; k < N; k++) mcol[k] = 4'((k / 2) % NC);
        i = N - 1;
        mshuf = 0;
        while (i >= 1 && mshuf < 100000) begin
            j = l[5:0];
            fb = l[15] ^ l[13] ^ l[12] ^ l[10];
            l = {l[14:0], fb};
            mshuf++;
            if (int'(j) <= i) begin
                t = mcol[i];
                mcol[i] = mcol[j];
                mcol[j] = t;
                i--;
            end
        end
    endtask

    function automatic logic [12:0] cell_exp(input logic [3:0] c);
        return {c, 1'b1, pal[c]};
    endfunction

    task automatic rd_cell(input int a, input logic [12:0] e,
                           input string tag);
        rd_addr = AW'(a);
        rd_q.push_back(e);
        tick();
        chk(tag, {rd_color, rd_present, r, g, b}, rd_q.pop_front());
    endtask

    task automatic read_layout(input string tag);
        int cnt [NC];
        int ecnt [NC];
        for (int c = 0; c < NC; c++) begin
            cnt[c] = 0;
            ecnt[c] = 0;
        end
        for (int i = 0; i < N; i++) begin
            ecnt[(i / 2) % NC]++;
            rd_cell(i, cell_exp(mcol[i]), tag);
            if (int'(rd_color) < NC) cnt[rd_color]++;
        end
        for (int c = 0; c < NC; c++) begin
            chk({tag, "_even"}, 32'(cnt[c] % 2), 32'd0);
            chk({tag, "_count"}, 32'(cnt[c]), 32'(ecnt[c]));
        end
    endtask

    task automatic wait_ready(input string tag, input int spent);
        int n;
        n = spent;
        while (!ready && n < 3000) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(N + mshuf));
        exp_rem = N;
        chk({tag, "_rem"}, 32'(remaining), 32'(exp_rem));
    endtask

    task automatic do_restart(input logic [15:0] sd);
        seed = sd;
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic rm_one(input int a, input int bb, input logic em,
                          input string tag);
        rm_addr_a = AW'(a);
        rm_addr_b = AW'(bb);
        rm_req = 1'b1;
        rm_q.push_back(em);
        tick();
        chk({tag, "_noack"}, 32'(rm_ack), 32'd0);
        rm_req = 1'b0;
        tick();
        chk({tag, "_ack"}, 32'(rm_ack), 32'd1);
        chk({tag, "_match"}, 32'(rm_match), 32'(rm_q.pop_front()));
        if (em) exp_rem -= 2;
        chk({tag, "_rem"}, 32'(remaining), 32'(exp_rem));
    endtask

    initial begin
        int p;
        int a;
        int bq;
        int np;
        int prev;
        int acks;

        repeat (3) tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rem", 32'(remaining), 32'd0);
        chk("rst_clear", 32'(board_clear), 32'd0);
        chk("rst_ack", 32'(rm_ack), 32'd0);
        chk("rst_rd", {rd_color, rd_present, r, g, b}, 32'd0);

        build(DSEED);
        rst_n = 1'b1;
        wait_ready("boot", 0);
        read_layout("layout0");

        rd_cell(0, cell_exp(mcol[0]), "rd_c0");
        p = 1;
        while (p < N - 1 && mcol[p] == mcol[0]) p++;
        rd_addr = AW'(p);
        #1;
        chk("rd_hold", 32'(rd_color), 32'(mcol[0]));
        rd_cell(36, 13'd0, "rd_oob36");
        rd_cell(40, 13'd0, "rd_oob40");

        p = 1;
        while (p < N - 1 && mcol[p] != mcol[0]) p++;
        rm_one(0, p, 1'b1, "rm_pair");
        rd_cell(0, 13'd0, "rd_gone_a");
        rd_cell(p, 13'd0, "rd_gone_b");
        rm_one(0, p, 1'b0, "rm_repeat");

        a = 1;
        while (a == p) a++;
        bq = 1;
        while (bq == p || mcol[bq] == mcol[a]) bq++;
        rm_one(a, bq, 1'b0, "rm_diff");
        rm_one(a, a, 1'b0, "rm_same");
        rm_one(37, a, 1'b0, "rm_oob");

        do_restart(16'd0);
        rm_addr_a = AW'(a);
        rm_addr_b = AW'(a);
        rm_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rm_early_noack", 32'(rm_ack), 32'd0);
        end
        rm_req = 1'b0;
        wait_ready("seed0", 3);
        read_layout("layout_seed0");

        np = 0;
        for (int c = 0; c < NC; c++) begin
            prev = -1;
            for (int i = 0; i < N; i++) begin
                if (int'(mcol[i]) == c) begin
                    if (prev < 0) begin
                        prev = i;
                    end else begin
                        pa[np] = prev;
                        pb[np] = i;
                        np++;
                        prev = -1;
                    end
                end
            end
        end
        acks = 0;
        for (int k = 0; k < 18; k++) begin
            rm_addr_a = AW'(pa[k]);
            rm_addr_b = AW'(pb[k]);
            rm_req = 1'b1;
            rm_q.push_back(1'b1);
            tick();
            if (k > 0) begin
                if (rm_ack) acks++;
                chk("b2b_match", 32'(rm_match), 32'(rm_q.pop_front()));
            end
        end
        rm_req = 1'b0;
        tick();
        if (rm_ack) acks++;
        chk("b2b_match", 32'(rm_match), 32'(rm_q.pop_front()));
        chk("b2b_acks", 32'(acks), 32'd18);
        chk("b2b_rem", 32'(remaining), 32'd0);
        chk("b2b_clear", 32'(board_clear), 32'd1);
        tick();
        chk("b2b_ack_pulse", 32'(rm_ack), 32'd0);

        rm_addr_a = 6'd0;
        rm_addr_b = 6'd1;
        rm_req = 1'b1;
        tick();
        rm_req = 1'b0;
        do_restart(16'h1234);
        chk("rs_ack_drop", 32'(rm_ack), 32'd0);
        chk("rs_ready", 32'(ready), 32'd0);
        chk("rs_rem", 32'(remaining), 32'd0);
        chk("rs_clear", 32'(board_clear), 32'd0);
        chk("rs_rd", {rd_color, rd_present, r, g, b}, 32'd0);
        repeat (N + 3) tick();
        chk("shuf_notready", 32'(ready), 32'd0);
        do_restart(16'h1234);
        chk("rs2_ready", 32'(ready), 32'd0);
        chk("rs2_rem", 32'(remaining), 32'd0);
        build(16'h1234);
        wait_ready("seed1234", 0);
        read_layout("layout_1234a");
        do_restart(16'h1234);
        wait_ready("seed1234b", 0);
        read_layout("layout_1234b");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
